vga_frame_capture: RTL and testbench

Captures one VGA frame from the filter GPU's video output stream (`vsync`, `hsync`, `blank`, `r`, `g`, `b`) and writes it pixel by pixel into an external frame memory. It is the receiving end of the VGA interface driven by `main`. It lets benches and on-chip self-check logic recover the filtered image for comparison against golden kernel results. It runs in the system `clk` domain and samples the stream on a one-cycle pixel strobe.

---
 rtl/vga_frame_capture_if.sv | 30 +++
 rtl/vga_frame_capture.sv | 168 ++++++++++++++++
 tb/tb_vga_frame_capture.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_capture_if.sv
// Bundles the VGA stream, capture control/status, and frame-memory write port.
// The master drives the stream and arm; the slave is the capture block.
interface vga_frame_capture_if #(
  parameter int ADDR_W = 19
);
  logic              pix_en;
  logic              arm;
  logic              vsync;
  logic              hsync;
  logic              blank;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output pix_en, arm, vsync, hsync, blank, r, g, b,
    input  busy, done, frame_err, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_en, arm, vsync, hsync, blank, r, g, b,
    output busy, done, frame_err, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Captures one VGA frame into an external frame memory, one write per active pixel.
// Define CAPTURE_GRAY_EN to store (r + 2g + b) >> 2 instead of the green channel.
module vga_frame_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  vga_frame_capture_if.slave bus
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH);
  localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic              vsync_prev_q, vsync_prev_d;
  logic              blank_prev_q, blank_prev_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic       vsync_fall;
  logic       blank_fall;
  logic       last_line;
  logic       pixel_ok;
  logic [7:0] pix_data;

`ifdef CAPTURE_GRAY_EN
  logic [9:0] gray_sum;
  logic       unused_inputs;
  assign gray_sum      = {2'b00, bus.r} + {1'b0, bus.g, 1'b0} + {2'b00, bus.b};
  assign pix_data      = gray_sum[9:2];
  assign unused_inputs = ^{bus.hsync, gray_sum[1:0]};
`else
  logic unused_inputs;
  assign pix_data      = bus.g;
  assign unused_inputs = ^{bus.hsync, bus.r, bus.b};
`endif

  assign vsync_fall = bus.pix_en & vsync_prev_q & ~bus.vsync;
  assign blank_fall = bus.pix_en & blank_prev_q & ~bus.blank;
  assign last_line  = (y_q + YW'(1)) == Y_MAX;
  assign pixel_ok   = (x_q < X_MAX) && (y_q < Y_MAX);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_base_d  = line_base_q;
    addr_ptr_d   = addr_ptr_q;
    vsync_prev_d = vsync_prev_q;
    blank_prev_d = blank_prev_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    frame_err_d  = frame_err_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (bus.pix_en) begin
      vsync_prev_d = bus.vsync;
      blank_prev_d = bus.blank;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d     = ST_ARMED;
          frame_err_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_ARMED: begin
        if (vsync_fall) begin
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
          addr_ptr_d  = '0;
          state_d     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.pix_en && bus.blank) begin
          if (pixel_ok) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_ptr_q;
            wr_data_d  = pix_data;
            x_d        = x_q + XW'(1);
            addr_ptr_d = addr_ptr_q + ADDR_W'(1);
          end else begin
            frame_err_d = 1'b1;
          end
        end
        // Every line restarts at its own base, so a bad line cannot skew the next one.
        if (blank_fall) begin
          if (x_q != X_MAX) frame_err_d = 1'b1;
          x_d         = '0;
          y_d         = y_q + YW'(1);
          line_base_d = line_base_q + LINE_STEP;
          addr_ptr_d  = line_base_q + LINE_STEP;
          if (last_line) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        if (vsync_fall && !(blank_fall && last_line)) begin
          frame_err_d = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      line_base_q  <= '0;
      addr_ptr_q   <= '0;
      vsync_prev_q <= 1'b1;
      blank_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_base_q  <= line_base_d;
      addr_ptr_q   <= addr_ptr_d;
      vsync_prev_q <= vsync_prev_d;
      blank_prev_q <= blank_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_vga_frame_capture.sv
// Randomised frame bench for vga_frame_capture with a frame-level reference model
// (expected writes derived from line lengths, geometry and colour rule).
module tb_vga_frame_capture;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
`ifdef CAPTURE_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_frame_capture_if #(.ADDR_W(AW)) bus ();

  vga_frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  tests_run    = 0;
  int  tests_failed = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  line_len[4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pix(input int rr, input int gg, input int bb);
    return GRAY ? ((rr + 2 * gg + bb) / 4) % 256 : gg;
  endfunction

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) got_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
    if (bus.done === 1'b1) begin
      done_cnt++;
      check_eq("busy_at_done", bus.busy, 0);
    end
  end

  task automatic sample(input logic en, input logic vs, input logic hs, input logic bl,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    bus.vsync  = vs;
    bus.hsync  = hs;
    bus.blank  = bl;
    bus.r      = rr;
    bus.g      = gg;
    bus.b      = bb;
    bus.pix_en = en;
    @(posedge clk); #1;
    bus.pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_sample(input logic vs);
    sample(1'b1, vs, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_arm();
    check_eq("busy_before_arm", bus.busy, 0);
    bus.arm = 1'b1;
    @(posedge clk); #1;
    bus.arm = 1'b0;
    @(negedge clk);
    check_eq("busy_after_arm", bus.busy, 1);
    check_eq("err_clear_on_arm", bus.frame_err, 0);
    @(posedge clk); #1;
  endtask

  // One active pixel; the model records where it should land, if anywhere.
  task automatic pixel(input int line, input int col, input bit fixed, input logic [23:0] rgb,
                       input bit armed);
    logic [7:0] rr, gg, bb;
    rr = fixed ? rgb[23:16] : 8'($urandom_range(0, 255));
    gg = fixed ? rgb[15:8]  : 8'($urandom_range(0, 255));
    bb = fixed ? rgb[7:0]   : 8'($urandom_range(0, 255));
    if (armed && line < H && col < W)
      exp_q.push_back('{line * W + col, exp_pix(int'(rr), int'(gg), int'(bb))});
    sample(1'b1, 1'b1, 1'b1, 1'b1, rr, gg, bb);
  endtask

  task automatic send_frame(input int nlines, input bit fixed, input logic [23:0] rgb,
                            input bit armed);
    idle_sample(1'b1);
    idle_sample(1'b1);
    idle_sample(1'b0);
    idle_sample(1'b0);
    idle_sample(1'b1);
    idle_sample(1'b1);
    for (int i = 0; i < nlines; i++) begin
      for (int j = 0; j < line_len[i]; j++) pixel(i, j, fixed, rgb, armed);
      idle_sample(1'b1);
      sample(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle_sample(1'b1);
    end
    if (nlines < H) begin
      idle_sample(1'b0);
      idle_sample(1'b1);
    end
    idle_sample(1'b1);
    idle_sample(1'b1);
    idle_sample(1'b0);
    idle_sample(1'b1);
  endtask

  task automatic finish_frame(input string name, input int exp_err, input int exp_done);
    int n;
    check_eq({name, "_nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({name, "_addr"}, got_q[i].addr, exp_q[i].addr);
      check_eq({name, "_data"}, got_q[i].data, exp_q[i].data);
    end
    check_eq({name, "_done"}, done_cnt, exp_done);
    check_eq({name, "_err"}, bus.frame_err, exp_err);
    check_eq({name, "_busy"}, bus.busy, 0);
    $display("[TB] frame %s: writes=%0d/%0d done=%0d err=%0b", name, got_q.size(),
             exp_q.size(), done_cnt, bus.frame_err);
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  function automatic int frame_bad(input int nlines);
    int bad;
    bad = (nlines < H) ? 1 : 0;
    for (int i = 0; i < nlines; i++) if (line_len[i] != W) bad = 1;
    return bad;
  endfunction

  task automatic run_frame(input string name, input int nlines, input bit fixed,
                           input logic [23:0] rgb);
    do_arm();
    send_frame(nlines, fixed, rgb, 1'b1);
    finish_frame(name, frame_bad(nlines), 1);
  endtask

  initial begin
    bus.pix_en = 1'b0;
    bus.arm    = 1'b0;
    bus.vsync  = 1'b1;
    bus.hsync  = 1'b1;
    bus.blank  = 1'b0;
    bus.r      = '0;
    bus.g      = '0;
    bus.b      = '0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.frame_err, 0);
    check_eq("rst_wr_en", bus.wr_en, 0);
    check_eq("rst_wr_addr", bus.wr_addr, 0);
    check_eq("rst_wr_data", bus.wr_data, 0);
    @(posedge clk); #1;

    // Stream activity without pix_en, then a sampled frame without arm: nothing captured.
    for (int k = 0; k < 24; k++)
      sample(1'b0, k[2], 1'b1, k[0], 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 4; i++) line_len[i] = W;
    send_frame(H, 1'b1, 24'hFFFFFF, 1'b0);
    finish_frame("no_arm", 0, 0);

    run_frame("red", H, 1'b1, 24'hFF0000);
    run_frame("white", H, 1'b1, 24'hFFFFFF);
    run_frame("green5a", H, 1'b1, 24'h005A00);
    for (int f = 0; f < 3; f++) run_frame("rand_normal", H, 1'b0, 24'h0);

    line_len[0] = 3; line_len[1] = W;
    run_frame("short_line", H, 1'b0, 24'h0);
    line_len[0] = 5; line_len[1] = W;
    run_frame("long_line", H, 1'b0, 24'h0);
    line_len[0] = W;
    run_frame("early_vsync", 1, 1'b0, 24'h0);
    line_len[1] = W;
    run_frame("rearm_clean", H, 1'b0, 24'h0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) line_len[i] = $urandom_range(1, 6);
      run_frame("rand_geom", $urandom_range(1, H), 1'b0, 24'h0);
    end

    // Reset after three writes aborts the frame; the rest of the stream is ignored.
    for (int i = 0; i < 4; i++) line_len[i] = W;
    do_arm();
    idle_sample(1'b1);
    idle_sample(1'b0);
    idle_sample(1'b1);
    for (int j = 0; j < 3; j++) pixel(0, j, 1'b0, 24'h0, 1'b1);
    check_eq("pre_reset_writes", got_q.size(), 3);
    #3 reset = 1'b1;
    #1;
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    check_eq("arst_err", bus.frame_err, 0);
    check_eq("arst_wr_en", bus.wr_en, 0);
    check_eq("arst_wr_addr", bus.wr_addr, 0);
    check_eq("arst_wr_data", bus.wr_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    pixel(0, 3, 1'b0, 24'h0, 1'b0);
    idle_sample(1'b1);
    for (int j = 0; j < W; j++) pixel(1, j, 1'b0, 24'h0, 1'b0);
    idle_sample(1'b1);
    idle_sample(1'b0);
    idle_sample(1'b1);
    finish_frame("reset_abort", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
